// File: rtl/cpu_pkg.sv
// Shared CPU definitions: datapath widths, the opcodes the MEM/WB stage
// decodes, and the MEM/WB handshake states.
package cpu_pkg;
    localparam int XLEN   = 32;
    localparam int REG_AW = 5;

    localparam logic [5:0] OP_LW  = 6'h23;
    localparam logic [5:0] OP_SW  = 6'h2B;
    localparam logic [5:0] OP_MUL = 6'h1C;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } state_t;
endpackage

// File: rtl/mem_wb_stage_if.sv
// Data-memory request/acknowledge bus between the MEM/WB stage (master)
// and the data memory (slave).
interface mem_wb_stage_if;
    import cpu_pkg::*;

    logic            mem_req;
    logic            mem_we;
    logic [XLEN-1:0] mem_addr;
    logic [XLEN-1:0] mem_wdata;
    logic            mem_ack;
    logic [XLEN-1:0] mem_rdata;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_ack, mem_rdata
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_ack, mem_rdata
    );
endinterface

// File: rtl/mem_wb_stage_wb_result_mux.sv
// Writeback result select: load data for loads, multiplier result for
// multiplies, ALU result for everything else.
module wb_result_mux
    import cpu_pkg::*;
(
    input  logic [5:0]      opcode,
    input  logic [XLEN-1:0] load_q,
    input  logic [XLEN-1:0] multiply,
    input  logic [XLEN-1:0] alu_out,
    output logic [XLEN-1:0] result
);
    always_comb begin
        result = alu_out;
        if (opcode == OP_LW) begin
            result = load_q;
        end else if (opcode == OP_MUL) begin
            result = multiply;
        end
    end
endmodule

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline stage: runs one data-memory transaction for loads and
// stores while stalling upstream, then retires with a registered RF write.
module mem_wb_stage
    import cpu_pkg::*;
(
    input  logic              clock,
    input  logic              reset,
    input  logic [5:0]        opcode_d2,
    input  logic [REG_AW-1:0] rd_d2,
    input  logic              register_we_d2,
    input  logic              data_we_d2,
    input  logic [XLEN-1:0]   reg_rs1_d2,
    input  logic [XLEN-1:0]   sum_d2,
    input  logic [XLEN-1:0]   alu_out_d2,
    input  logic [XLEN-1:0]   multiply_d2,
    output logic              stall,
    mem_wb_stage_if.master    mem,
    output logic              wb_we,
    output logic [REG_AW-1:0] wb_rd,
    output logic [XLEN-1:0]   wb_data
);
    state_t            r_state;
    state_t            w_state_next;
    logic              r_mem_req;
    logic              r_mem_we;
    logic [XLEN-1:0]   r_mem_addr;
    logic [XLEN-1:0]   r_mem_wdata;
    logic [XLEN-1:0]   r_load_q;
    logic              r_wb_we;
    logic [REG_AW-1:0] r_wb_rd;
    logic [XLEN-1:0]   r_wb_data;

    logic              w_mem_op;
    logic              w_issue;
    logic              w_ack;
    logic              w_retire;
    logic [XLEN-1:0]   w_wb_data;

    assign w_mem_op = (opcode_d2 == OP_LW) || data_we_d2;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // DONE always returns to IDLE so the held bundle cannot re-issue.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (w_mem_op) w_state_next = REQ;
            REQ:     if (mem.mem_ack) w_state_next = DONE;
            DONE:    w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_comb begin
        stall    = 1'b0;
        w_issue  = 1'b0;
        w_ack    = 1'b0;
        w_retire = 1'b0;
        case (r_state)
            IDLE: begin
                stall    = w_mem_op;
                w_issue  = w_mem_op;
                w_retire = !w_mem_op;
            end
            REQ: begin
                stall = 1'b1;
                w_ack = mem.mem_ack;
            end
            DONE:    w_retire = 1'b1;
            default: ;
        endcase
    end

    wb_result_mux u_wb_result_mux (
        .opcode   (opcode_d2),
        .load_q   (r_load_q),
        .multiply (multiply_d2),
        .alu_out  (alu_out_d2),
        .result   (w_wb_data)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_load_q    <= '0;
            r_wb_we     <= 1'b0;
            r_wb_rd     <= '0;
            r_wb_data   <= '0;
        end else begin
            if (w_issue) begin
                r_mem_req   <= 1'b1;
                r_mem_we    <= data_we_d2;
                r_mem_addr  <= sum_d2;
                r_mem_wdata <= reg_rs1_d2;
            end else if (w_ack) begin
                r_mem_req <= 1'b0;
                r_load_q  <= mem.mem_rdata;
            end

            if (w_retire) begin
                // Stores never write the register file, whatever register_we says.
                r_wb_we   <= register_we_d2 && (rd_d2 != '0) && !data_we_d2;
                r_wb_rd   <= rd_d2;
                r_wb_data <= w_wb_data;
            end else begin
                r_wb_we <= 1'b0;
            end
        end
    end

    assign mem.mem_req   = r_mem_req;
    assign mem.mem_we    = r_mem_we;
    assign mem.mem_addr  = r_mem_addr;
    assign mem.mem_wdata = r_mem_wdata;
    assign wb_we         = r_wb_we;
    assign wb_rd         = r_wb_rd;
    assign wb_data       = r_wb_data;
endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed bench for mem_wb_stage: a table of single-cycle ops plus
// hand-written load/store/reset sequences.
module tb_mem_wb_stage;
    import cpu_pkg::*;

    localparam logic [5:0] OP_ADD = 6'h20;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [5:0]  opcode_d2 = OP_ADD;
    logic [4:0]  rd_d2 = '0;
    logic        register_we_d2 = 1'b0;
    logic        data_we_d2 = 1'b0;
    logic [31:0] reg_rs1_d2 = '0;
    logic [31:0] sum_d2 = '0;
    logic [31:0] alu_out_d2 = '0;
    logic [31:0] multiply_d2 = '0;
    logic        stall;
    logic        wb_we;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;

    int checks = 0;
    int failures = 0;

    mem_wb_stage_if mem_bus ();

    mem_wb_stage dut (
        .clock          (clock),
        .reset          (reset),
        .opcode_d2      (opcode_d2),
        .rd_d2          (rd_d2),
        .register_we_d2 (register_we_d2),
        .data_we_d2     (data_we_d2),
        .reg_rs1_d2     (reg_rs1_d2),
        .sum_d2         (sum_d2),
        .alu_out_d2     (alu_out_d2),
        .multiply_d2    (multiply_d2),
        .stall          (stall),
        .mem            (mem_bus.master),
        .wb_we          (wb_we),
        .wb_rd          (wb_rd),
        .wb_data        (wb_data)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [5:0]  opcode;
        logic [4:0]  rd;
        logic        reg_we;
        logic [31:0] alu;
        logic [31:0] mul;
        logic        ack;
        logic        exp_we;
        logic [31:0] exp_data;
    } vec_t;

    vec_t vecs [5];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive_nop();
        opcode_d2      = OP_ADD;
        rd_d2          = '0;
        register_we_d2 = 1'b0;
        data_we_d2     = 1'b0;
        mem_bus.mem_ack = 1'b0;
    endtask

    // Entered and left one time unit after a rising edge.
    task automatic mem_op(input string name, input logic [5:0] op, input logic dwe,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [4:0] rd, input logic rwe, input int ack_cycle,
                          input logic [31:0] rdata, input logic exp_we);
        opcode_d2      = op;
        data_we_d2     = dwe;
        sum_d2         = addr;
        reg_rs1_d2     = wdata;
        rd_d2          = rd;
        register_we_d2 = rwe;
        mem_bus.mem_ack = 1'b0;
        #1 chk({name, " stall_issue"}, 32'(stall), 32'd1);
        @(posedge clock); #1;
        for (int i = 1; i <= ack_cycle; i++) begin
            chk({name, " mem_req"}, 32'(mem_bus.mem_req), 32'd1);
            chk({name, " mem_we"}, 32'(mem_bus.mem_we), 32'(dwe));
            chk({name, " mem_addr"}, mem_bus.mem_addr, addr);
            chk({name, " mem_wdata"}, mem_bus.mem_wdata, wdata);
            chk({name, " stall_req"}, 32'(stall), 32'd1);
            chk({name, " wb_we_req"}, 32'(wb_we), 32'd0);
            if (i == ack_cycle) begin
                mem_bus.mem_ack   = 1'b1;
                mem_bus.mem_rdata = rdata;
            end
            @(posedge clock); #1;
        end
        mem_bus.mem_ack = 1'b0;
        chk({name, " mem_req_done"}, 32'(mem_bus.mem_req), 32'd0);
        #1 chk({name, " stall_done"}, 32'(stall), 32'd0);
        chk({name, " wb_we_done"}, 32'(wb_we), 32'd0);
        @(posedge clock); #1;
        drive_nop();
        chk({name, " wb_we"}, 32'(wb_we), 32'(exp_we));
        if (exp_we) begin
            chk({name, " wb_rd"}, 32'(wb_rd), 32'(rd));
            chk({name, " wb_data"}, wb_data, rdata);
        end
        $display("%s: op=%h addr=%h ack_cycle=%0d wb_we=%0b wb_data=%h",
                 name, op, addr, ack_cycle, wb_we, wb_data);
    endtask

    initial begin
        mem_bus.mem_ack   = 1'b0;
        mem_bus.mem_rdata = '0;

        vecs[0] = '{OP_ADD, 5'd3, 1'b1, 32'h1234,     32'h0,        1'b0, 1'b1, 32'h1234};
        vecs[1] = '{OP_MUL, 5'd0, 1'b1, 32'h9,        32'h00010000, 1'b0, 1'b0, 32'h00010000};
        vecs[2] = '{OP_MUL, 5'd7, 1'b1, 32'h9,        32'h00010000, 1'b0, 1'b1, 32'h00010000};
        vecs[3] = '{OP_ADD, 5'd9, 1'b0, 32'h55,       32'h0,        1'b0, 1'b0, 32'h55};
        vecs[4] = '{OP_ADD, 5'd4, 1'b1, 32'hCAFE,     32'h0,        1'b1, 1'b1, 32'hCAFE};

        #2;
        chk("reset mem_req", 32'(mem_bus.mem_req), 32'd0);
        chk("reset mem_addr", mem_bus.mem_addr, 32'd0);
        chk("reset wb_we", 32'(wb_we), 32'd0);
        chk("reset wb_rd", 32'(wb_rd), 32'd0);
        chk("reset wb_data", wb_data, 32'd0);
        chk("reset stall", 32'(stall), 32'd0);
        @(posedge clock); #3 reset = 1'b0;
        @(posedge clock); #1;

        for (int i = 0; i < 5; i++) begin
            opcode_d2       = vecs[i].opcode;
            rd_d2           = vecs[i].rd;
            register_we_d2  = vecs[i].reg_we;
            data_we_d2      = 1'b0;
            alu_out_d2      = vecs[i].alu;
            multiply_d2     = vecs[i].mul;
            mem_bus.mem_ack = vecs[i].ack;
            #1 chk($sformatf("vec%0d stall", i), 32'(stall), 32'd0);
            @(posedge clock); #1;
            chk($sformatf("vec%0d wb_we", i), 32'(wb_we), 32'(vecs[i].exp_we));
            chk($sformatf("vec%0d wb_rd", i), 32'(wb_rd), 32'(vecs[i].rd));
            chk($sformatf("vec%0d wb_data", i), wb_data, vecs[i].exp_data);
            chk($sformatf("vec%0d mem_req", i), 32'(mem_bus.mem_req), 32'd0);
            $display("vec%0d: op=%h rd=%0d wb_we=%0b wb_rd=%0d wb_data=%h",
                     i, vecs[i].opcode, vecs[i].rd, wb_we, wb_rd, wb_data);
        end
        drive_nop();

        mem_op("load", OP_LW, 1'b0, 32'h100, 32'h0, 5'd5, 1'b1, 2, 32'hDEADBEEF, 1'b1);
        mem_op("store", OP_SW, 1'b1, 32'h40, 32'hA5A5A5A5, 5'd6, 1'b1, 1, 32'h11111111, 1'b0);
        mem_op("load_fast", OP_LW, 1'b0, 32'h104, 32'h0, 5'd8, 1'b1, 1, 32'h0BADF00D, 1'b1);

        // Abandon a load mid-REQ; outputs must clear before any clock edge.
        opcode_d2      = OP_LW;
        sum_d2         = 32'h200;
        rd_d2          = 5'd2;
        register_we_d2 = 1'b1;
        @(posedge clock); #1;
        chk("rst_req mem_req_before", 32'(mem_bus.mem_req), 32'd1);
        #2;
        reset = 1'b1;
        drive_nop();
        #1;
        chk("rst_req mem_req", 32'(mem_bus.mem_req), 32'd0);
        chk("rst_req wb_we", 32'(wb_we), 32'd0);
        chk("rst_req stall", 32'(stall), 32'd0);
        $display("reset_mid_req: mem_req=%0b wb_we=%0b stall=%0b", mem_bus.mem_req, wb_we, stall);
        @(posedge clock); #3 reset = 1'b0;
        @(posedge clock); #1;
        chk("rst_after wb_we", 32'(wb_we), 32'd0);
        mem_op("load_after_reset", OP_LW, 1'b0, 32'h300, 32'h0, 5'd12, 1'b1, 3, 32'h12345678, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/mem_wb_stage.md
# mem_wb_stage

Memory-access and writeback stage fed by the EX/MEM pipeline register. It consumes the `_d2` bundle, runs a request/acknowledge transaction with data memory for loads and stores, and stalls upstream while that transaction is pending. It retires every instruction by issuing one registered register-file write: ALU, multiply, or load data.

## Interface
- Parameters: none. Opcode constants come from the shared package.
- `clock  in  1` — rising-edge clock.
- `reset  in  1` — asynchronous, active-high.
- `opcode_d2  in  6` — opcode of the instruction in this stage.
- `rd_d2  in  5` — destination register.
- `register_we_d2  in  1` — instruction writes a register.
- `data_we_d2  in  1` — instruction writes memory (store).
- `reg_rs1_d2  in  32` — store data.
- `sum_d2  in  32` — effective memory address.
- `alu_out_d2  in  32` — ALU result.
- `multiply_d2  in  32` — multiplier result.
- `stall  out  1` — combinational; upstream holds the `_d2` bundle while it is high.
- `mem_req  out  1` — registered memory request.
- `mem_we  out  1` — registered; 1 = write.
- `mem_addr  out  32` — registered address.
- `mem_wdata  out  32` — registered write data.
- `mem_ack  in  1` — memory completion; valid only while `mem_req` = 1.
- `mem_rdata  in  32` — load data; valid in the `mem_ack` cycle.
- `wb_we  out  1` — registered register-file write strobe, one cycle per retire.
- `wb_rd  out  5` — registered write address.
- `wb_data  out  32` — registered write data.

## Operation
- Memory op = (`opcode_d2` == `OP_LW`) or `data_we_d2`.
- States:
  - **IDLE**
    - Memory op present: `stall` = 1. At the clock edge, latch `mem_addr` ← `sum_d2`, `mem_wdata` ← `reg_rs1_d2`, `mem_we` ← `data_we_d2`, `mem_req` ← 1, then go to REQ.
    - Otherwise: retire the instruction this edge and stay in IDLE.
  - **REQ**
    - `stall` = 1 and `mem_req` held at 1.
    - `mem_ack` = 1: capture `mem_rdata` into `load_q`, clear `mem_req`, go to DONE.
    - Otherwise: stay in REQ with no timeout.
  - **DONE**
    - `stall` = 0; the bundle is still the same memory instruction.
    - Retire it this edge and go to IDLE unconditionally, so the instruction never re-triggers.
- Retire (registered update of the `wb_*` outputs):
  - `wb_we` ← `register_we_d2` && (`rd_d2` != 0) && !`data_we_d2`.
  - `wb_rd` ← `rd_d2`.
  - `wb_data` ← `load_q` for `OP_LW`, `multiply_d2` for `OP_MUL`, else `alu_out_d2`.
- Non-retire cycles: `wb_we` ← 0; `wb_rd` and `wb_data` hold their values.
- Stores never write a register, even if `register_we_d2` = 1.
- `mem_ack` outside REQ is ignored, with no state change.
- `mem_ack` arriving in the same cycle as `mem_req` first rises is impossible, because `mem_req` is registered. An ack in the first REQ cycle is legal.

## Timing
- Reset (async): state = IDLE, `mem_req` = 0, `mem_we` = 0, `mem_addr` = 0, `mem_wdata` = 0, `load_q` = 0, `wb_we` = 0, `wb_rd` = 0, `wb_data` = 0. `stall` then follows IDLE decoding.
- Reset during REQ: `mem_req` drops immediately and asynchronously; the transaction is abandoned and no writeback occurs.
- Non-memory op: bundle presented in cycle t; `wb_*` valid in cycle t+1; throughput one per cycle; `stall` = 0.
- Memory op:
  - Bundle presented in cycle t, with `stall` = 1 in t.
  - `mem_req` = 1 from t+1 until the cycle in which `mem_ack` is sampled (cycle k).
  - DONE in k+1; `wb_we` pulses in k+2 for loads.
  - `stall` = 1 from t through k inclusive.
  - Minimum load latency (ack at t+1) is 3 cycles to `wb_we`; minimum occupancy is 3 cycles.
- `mem_addr`, `mem_wdata` and `mem_we` are stable for the whole time `mem_req` is high.
- Back-to-back memory ops: DONE → IDLE adds no bubble beyond DONE; the next op starts stalling in the IDLE cycle.

## Structure
- Shared package `cpu_pkg` holds:
  - opcodes `OP_LW` = 6'h23, `OP_SW` = 6'h2B, `OP_MUL` = 6'h1C;
  - state enum {IDLE, REQ, DONE};
  - `XLEN` = 32 and `REG_AW` = 5.
- One natural sub-module: `wb_result_mux`, the combinational selection of `wb_data` from `load_q`/`multiply_d2`/`alu_out_d2` by opcode.

## Test plan
- ALU op: `opcode` = add, `rd` = 3, `alu_out` = 32'h1234, `register_we` = 1 → `wb_we` = 1, `wb_rd` = 3, `wb_data` = 32'h1234 next cycle, `stall` never high.
- Load: `OP_LW`, `sum` = 32'h100, `rd` = 5; ack after 2 REQ cycles with `rdata` = 32'hDEADBEEF → `mem_req` high exactly 2 cycles, `mem_we` = 0, `mem_addr` = 32'h100, `wb_data` = 32'hDEADBEEF two cycles after ack, `stall` high from issue through the ack cycle.
- Store: `data_we` = 1, `sum` = 32'h40, `reg_rs1` = 32'hA5A5A5A5, ack in the first REQ cycle → `mem_we` = 1, `mem_wdata` = 32'hA5A5A5A5, `wb_we` stays 0 throughout.
- `OP_MUL` with `multiply` = 32'h00010000 and `rd` = 0 → `wb_we` = 0; same with `rd` = 7 → `wb_we` = 1, `wb_data` = 32'h00010000.
- Spurious `mem_ack` = 1 while in IDLE on an ALU op → no state change, `mem_req` stays 0, normal writeback.
- Assert `reset` mid-REQ → `mem_req`, `wb_we` and `stall` clear without waiting for a clock edge; after release, a fresh load completes normally.
